// File: rtl/base_ram_arbiter.sv
// rtl/base_ram_arbiter.sv - round-robin arbiter sharing one asynchronous base SRAM between fetch and data ports
module base_ram_arbiter #(
  parameter int READ_CYCLES  = 2,
  parameter int WRITE_CYCLES = 2
) (
  input  logic        clk_50M,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  output logic        mem_ack,
  output logic [31:0] mem_rdata,
  inout  wire  [31:0] base_ram_data,
  output logic [19:0] base_ram_addr,
  output logic [3:0]  base_ram_be_n,
  output logic        base_ram_ce_n,
  output logic        base_ram_oe_n,
  output logic        base_ram_we_n
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_WHOLD = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic GRANT_IF  = 1'b0;
  localparam logic GRANT_MEM = 1'b1;

  localparam logic [3:0] RD_LOAD = 4'(READ_CYCLES - 1);
  localparam logic [3:0] WR_LOAD = 4'(WRITE_CYCLES - 1);

  if (READ_CYCLES < 1 || READ_CYCLES > 15) begin : g_bad_read_cycles
    $error("READ_CYCLES must be in 1..15");
  end
  if (WRITE_CYCLES < 1 || WRITE_CYCLES > 15) begin : g_bad_write_cycles
    $error("WRITE_CYCLES must be in 1..15");
  end

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  logic [19:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic [3:0]  be_n_q, be_n_d;
  logic        bus_oe_q, bus_oe_d;
  logic        if_ack_q, if_ack_d;
  logic        mem_ack_q, mem_ack_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        pick_mem;
  logic        unused_addr_bits;

  // The data port wins only when it is alone or when the fetch port was served last.
  assign pick_mem = mem_req && (!if_req || last_grant_q == GRANT_IF);

  assign unused_addr_bits = ^{if_addr[31:22], if_addr[1:0], mem_addr[31:22], mem_addr[1:0]};

  always_comb begin
    state_d      = state_q;
    cnt_d        = (cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (if_req || mem_req) begin
          last_grant_d = pick_mem ? GRANT_MEM : GRANT_IF;
          addr_d       = pick_mem ? mem_addr[21:2] : if_addr[21:2];
          we_d         = pick_mem && mem_we;
          wstrb_d      = pick_mem ? mem_wstrb : 4'h0;
          wdata_d      = pick_mem ? mem_wdata : 32'h0;
          if (pick_mem && mem_we) begin
            state_d = S_WRITE;
            cnt_d   = WR_LOAD;
          end else begin
            state_d = S_READ;
            cnt_d   = RD_LOAD;
          end
        end
      end
      S_READ: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          cnt_d   = 4'd0;
          if (last_grant_q == GRANT_MEM) begin
            mem_rdata_d = base_ram_data;
          end else begin
            if_rdata_d = base_ram_data;
          end
        end
      end
      S_WRITE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_WHOLD;
          cnt_d   = 4'd0;
        end
      end
      S_WHOLD: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // SRAM strobes and acks are decoded from the next state so they leave flops aligned with it.
    ce_n_d    = !(state_d == S_READ || state_d == S_WRITE);
    oe_n_d    = (state_d != S_READ);
    we_n_d    = (state_d != S_WRITE);
    be_n_d    = (state_d == S_WRITE || state_d == S_WHOLD) ? ~wstrb_d : 4'h0;
    bus_oe_d  = (state_d == S_WRITE || state_d == S_WHOLD);
    if_ack_d  = (state_d == S_DONE || state_d == S_WHOLD) && last_grant_d == GRANT_IF;
    mem_ack_d = (state_d == S_DONE || state_d == S_WHOLD) && last_grant_d == GRANT_MEM;
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= GRANT_MEM;
      addr_q       <= 20'h0;
      we_q         <= 1'b0;
      wstrb_q      <= 4'h0;
      wdata_q      <= 32'h0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      be_n_q       <= 4'h0;
      bus_oe_q     <= 1'b0;
      if_ack_q     <= 1'b0;
      mem_ack_q    <= 1'b0;
      if_rdata_q   <= 32'h0;
      mem_rdata_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      be_n_q       <= be_n_d;
      bus_oe_q     <= bus_oe_d;
      if_ack_q     <= if_ack_d;
      mem_ack_q    <= mem_ack_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
    end
  end

  assign base_ram_data = bus_oe_q ? wdata_q : 32'bz;
  assign base_ram_addr = addr_q;
  assign base_ram_be_n = be_n_q;
  assign base_ram_ce_n = ce_n_q;
  assign base_ram_oe_n = oe_n_q;
  assign base_ram_we_n = we_n_q;
  assign if_ack        = if_ack_q;
  assign mem_ack       = mem_ack_q;
  assign if_rdata      = if_rdata_q;
  assign mem_rdata     = mem_rdata_q;

endmodule

// File: doc/base_ram_arbiter.md
BASE_RAM_ARBITER -- requirements
Module: base_ram_arbiter

Interface
REQ-001 Parameter READ_CYCLES, default 2, number of cycles ce_n/oe_n are held low per read; legal range 1..15.
REQ-002 Parameter WRITE_CYCLES, default 2, number of cycles we_n is held low per write; legal range 1..15.
REQ-003 clk_50M  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous reset, active-high.
REQ-005 if_req  in  1  instruction-fetch read request; held high until if_ack.
REQ-006 if_addr  in  32  fetch byte address; held stable while if_req is high.
REQ-007 if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid.
REQ-008 if_rdata  out  32  fetch read data, registered.
REQ-009 mem_req  in  1  data-port request; held high until mem_ack.
REQ-010 mem_we  in  1  1 = write, 0 = read; held stable with mem_req.
REQ-011 mem_addr  in  32  data byte address; held stable with mem_req.
REQ-012 mem_wstrb  in  4  write byte strobes, active-high.
REQ-013 mem_wdata  in  32  write data.
REQ-014 mem_ack  out  1  one-cycle pulse: data access complete.
REQ-015 mem_rdata  out  32  data read result, registered; valid with mem_ack on reads.
REQ-016 base_ram_data  inout  32  SRAM data bus; driven only during the write and write-hold states, high-Z otherwise.
REQ-017 base_ram_addr  out  20  SRAM word address, equal to granted addr[21:2].
REQ-018 base_ram_be_n  out  4  byte enables, active-low.
REQ-019 base_ram_ce_n, base_ram_oe_n, base_ram_we_n  out  1 each  chip select, output enable and write enable, active-low, all registered.

Function
REQ-020 The FSM SHALL use states IDLE, READ, WRITE, WHOLD (write hold) and DONE.
REQ-021 IDLE: when any request is high, the FSM SHALL latch the winner's addr, we, wstrb and wdata, then go to READ or WRITE.
REQ-022 Arbitration SHALL be round-robin: with both requests high, the port not granted last wins; with one request high, that port wins.
REQ-023 Register last_grant SHALL reset to "mem", so the fetch port wins the first tie.
REQ-024 READ: ce_n=0, oe_n=0, we_n=1, be_n=0000, bus high-Z, for exactly READ_CYCLES cycles; bus sampled on the final edge into rdata of the granted port; next state DONE.
REQ-025 WRITE: ce_n=0, we_n=0, oe_n=1, be_n=~wstrb, bus driven with wdata, for exactly WRITE_CYCLES cycles; next state WHOLD.
REQ-026 WHOLD (1 cycle): we_n=1, ce_n=1, oe_n=1; bus and addr still driven for hold time; granted port's ack=1; next IDLE.
REQ-027 DONE (1 cycle): ce_n=oe_n=we_n=1, bus high-Z; granted port's ack=1; next IDLE.
REQ-028 Read latency SHALL be READ_CYCLES+2 cycles from the request being sampled in IDLE to the ack cycle, inclusive of the ack cycle.
REQ-029 Write latency SHALL be WRITE_CYCLES+2 cycles, measured the same way.
REQ-030 Requests SHALL NOT be sampled in DONE/WHOLD; a requester deasserting after ack therefore never causes a duplicate access.
REQ-031 if_ack and mem_ack SHALL never be high in the same cycle; at most one SRAM access is outstanding.
REQ-032 A mem write with wstrb=0000 SHALL still run the full write sequence with be_n=1111 and ack normally.
REQ-033 rdata of the non-granted port SHALL hold its previous value.
REQ-034 The cycle counter SHALL be 4 bits and reload on every state entry; it SHALL not wrap within a state.

Reset
REQ-035 Reset SHALL force, on the next edge: state IDLE, ce_n=oe_n=we_n=1, be_n=0000, addr=0, bus high-Z, both acks 0, both rdata=0, last_grant=mem.
REQ-036 Reset asserted mid-access SHALL abort the access with no ack; a write's we_n SHALL rise on that edge.

Verification
REQ-037 Fetch read of 0x8000_0010 with SRAM word 4 = 0x1234_5678, defaults -> addr=0x00004 with ce_n/oe_n low for cycles 1-2, if_ack in cycle 3, if_rdata=0x1234_5678.
REQ-038 mem write 0x8000_0008, wdata 0xAABB_CCDD, wstrb 0101 -> be_n=1010 and we_n low for 2 cycles, then 1 hold cycle with data driven, mem_ack; readback = 0x??BB_??DD with untouched bytes preserved.
REQ-039 Both ports request in the same cycle out of reset, both held -> fetch granted first, mem second, then fetch again (alternating); no ack overlap.
REQ-040 Reset pulsed in cycle 1 of a write -> we_n=1 and bus high-Z on the next edge, no mem_ack, FSM in IDLE.
REQ-041 READ_CYCLES=1, WRITE_CYCLES=3, back-to-back fetches -> one ack every 3 cycles; a write shows we_n low for exactly 3 cycles.
